eth_tx_gate: RTL and testbench

// - Egress-side companion of the RX busy monitor: sits between the TX packet source and the 100G MAC TX AXIS port.
// - Forwards 512-bit AXIS packets with zero added latency, starts packets only on command,

---
 rtl/eth_tx_gate.sv | 146 ++++++++++++++
 tb/tb_eth_tx_gate.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_gate.sv
// eth_tx_gate
//   Egress gate between a TX packet source and a 100G MAC TX AXIS port.
//   Beats pass through combinationally with zero latency. A new packet may
//   start only while tx_enable is high. A programmable idle gap follows
//   every packet. Gating only ever acts on packet boundaries, so a packet
//   that has started always completes.
//
//   Handshake: a beat transfers in a cycle where S_AXIS_tvalid, M_AXIS_tready
//   and the internal "open" condition are all high. The source must hold a
//   beat stable while tvalid=1 and tready=0. M_AXIS_tvalid never depends on
//   M_AXIS_tready, and S_AXIS_tready never depends on S_AXIS_tvalid.
//
// Optional feature macro: ETH_TX_STATS_EN (packet / error-packet counters).
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   tx_enable          1 = a new packet may start (only looked at in IDLE)
//   gap_cycles         idle cycles forced after each tlast (captured at tlast)
//   eth_tx_busy        registered: packet in flight, gap running, or source valid
//   dbg_state          current FSM state (0 IDLE, 1 PASS, 2 GAP)
//   S_AXIS_*           source side (tdata/tkeep/tlast/tuser/tvalid in, tready out)
//   M_AXIS_*           MAC side (tdata/tkeep/tlast/tuser/tvalid out, tready in)
//   stat_pkts          packets completed                    (ETH_TX_STATS_EN)
//   stat_err_pkts      packets ending with tuser=1          (ETH_TX_STATS_EN)
//   stat_clear         synchronous clear of both counters   (ETH_TX_STATS_EN)
module eth_tx_gate #(
  parameter int GAP_W = 8
`ifdef ETH_TX_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tx_enable,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             eth_tx_busy,
  output logic [1:0]       dbg_state,
  input  logic [511:0]     S_AXIS_tdata,
  input  logic [63:0]      S_AXIS_tkeep,
  input  logic             S_AXIS_tlast,
  input  logic             S_AXIS_tuser,
  input  logic             S_AXIS_tvalid,
  output logic             S_AXIS_tready,
  output logic [511:0]     M_AXIS_tdata,
  output logic [63:0]      M_AXIS_tkeep,
  output logic             M_AXIS_tlast,
  output logic             M_AXIS_tuser,
  output logic             M_AXIS_tvalid,
  input  logic             M_AXIS_tready
`ifdef ETH_TX_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_pkts,
  output logic [CNT_W-1:0] stat_err_pkts,
  input  logic             stat_clear
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             open_w;
  logic             xfer;

  // Data path: pure wires, no storage.
  assign M_AXIS_tdata = S_AXIS_tdata;
  assign M_AXIS_tkeep = S_AXIS_tkeep;
  assign M_AXIS_tlast = S_AXIS_tlast;
  assign M_AXIS_tuser = S_AXIS_tuser;

  // Gate is closed while reset is asserted so nothing leaks to the MAC.
  assign open_w = resetn & ((state_q == S_PASS) | ((state_q == S_IDLE) & tx_enable));

  assign M_AXIS_tvalid = S_AXIS_tvalid & open_w;
  assign S_AXIS_tready = M_AXIS_tready & open_w;
  assign xfer          = S_AXIS_tvalid & M_AXIS_tready & open_w;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      eth_tx_busy <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      eth_tx_busy <= (state_d != S_IDLE) | S_AXIS_tvalid;
    end
  end

  // gap_cnt is loaded with N-1 so that GAP lasts exactly N cycles: the exit
  // test happens in the same cycle the counter reads zero.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE, S_PASS: begin
        if (xfer) begin
          if (S_AXIS_tlast) begin
            if (gap_cycles != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_cycles - GAP_ONE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_PASS;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ETH_TX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Clear wins over a coincident increment; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn || stat_clear) begin
      stat_pkts     <= '0;
      stat_err_pkts <= '0;
    end else if (xfer && S_AXIS_tlast) begin
      stat_pkts <= stat_pkts + CNT_ONE;
      if (S_AXIS_tuser) begin
        stat_err_pkts <= stat_err_pkts + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_gate.sv
// tb_eth_tx_gate
//   Bench for eth_tx_gate: reset checks, a table of single-cycle vectors,
//   hand-written packet sequences for gap / enable / reset corner cases and
//   a randomized stream checked against a timeline model of the gate.
module tb_eth_tx_gate;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  typedef struct {
    logic       en;
    logic       s_valid;
    logic       s_last;
    logic       m_ready;
    logic [7:0] gap;
    logic       exp_mv;
    logic       exp_sr;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         resetn;
  logic         tx_enable;
  logic [7:0]   gap_cycles;
  logic         eth_tx_busy;
  logic [1:0]   dbg_state;
  logic [511:0] S_AXIS_tdata;
  logic [63:0]  S_AXIS_tkeep;
  logic         S_AXIS_tlast;
  logic         S_AXIS_tuser;
  logic         S_AXIS_tvalid;
  logic         S_AXIS_tready;
  logic [511:0] M_AXIS_tdata;
  logic [63:0]  M_AXIS_tkeep;
  logic         M_AXIS_tlast;
  logic         M_AXIS_tuser;
  logic         M_AXIS_tvalid;
  logic         M_AXIS_tready;
`ifdef ETH_TX_STATS_EN
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_err_pkts;
  logic         stat_clear;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  eth_tx_gate dut (
    .clk           (clk),
    .resetn        (resetn),
    .tx_enable     (tx_enable),
    .gap_cycles    (gap_cycles),
    .eth_tx_busy   (eth_tx_busy),
    .dbg_state     (dbg_state),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tkeep  (S_AXIS_tkeep),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tuser  (S_AXIS_tuser),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tkeep  (M_AXIS_tkeep),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .M_AXIS_tuser  (M_AXIS_tuser),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready)
`ifdef ETH_TX_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_err_pkts (stat_err_pkts),
    .stat_clear    (stat_clear)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  logic [577:0] exp_q[$];
  beat_t        src_q[$];
  int           hs_cyc[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           m_beats = 0;

  // Timeline model: a packet is either in flight, or the next one may start
  // no earlier than cycle next_start (tlast cycle + gap + 1).
  bit           mdl_in_pkt = 1'b0;
  int           mdl_next_start = 0;
  int unsigned  mdl_pkts = 0;
  int unsigned  mdl_err = 0;

  // per-cycle stimulus knobs
  bit           rdy_rand = 1'b0;
  bit           en_rand = 1'b0;
  bit           gap_rand = 1'b0;
  bit           clr_on_last = 1'b0;
  bit           vec_on = 1'b0;
  bit           vec_mv, vec_sr;

  task automatic chk(input string name, input logic [577:0] act, input logic [577:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last, input bit user);
    beat_t b;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
    b.keep = {$urandom, $urandom};
    b.last = last;
    b.user = user;
    return b;
  endfunction

  task automatic add_pkt(input int len, input bit err);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1, (i == len - 1) ? err : 1'($urandom_range(0, 1)));
      src_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle: inputs are already applied; check combinational outputs
  // mid-cycle, advance the model, then check registered outputs after the edge.
  task automatic step();
    bit exp_open, xfer, m_hs, s_hs, clr_now;
    logic [577:0] got;
    #4;
    exp_open = resetn && (mdl_in_pkt || (cyc >= mdl_next_start && tx_enable));
    chk("m_tvalid", M_AXIS_tvalid, S_AXIS_tvalid & exp_open);
    chk("s_tready", S_AXIS_tready, M_AXIS_tready & exp_open);
    chk("passthru", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tuser},
        {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tuser});
    if (vec_on) begin
      chk("vec_mv", M_AXIS_tvalid, vec_mv);
      chk("vec_sr", S_AXIS_tready, vec_sr);
    end
    xfer = S_AXIS_tvalid && M_AXIS_tready && exp_open;
    m_hs = M_AXIS_tvalid && M_AXIS_tready;
    s_hs = S_AXIS_tvalid && S_AXIS_tready;
    if (m_hs) begin
      got = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tuser};
      if (exp_q.size() == 0) chk("sb_extra_beat", 1, 0);
      else chk("sb_beat", got, exp_q.pop_front());
      hs_cyc.push_back(cyc);
      m_beats++;
    end
`ifdef ETH_TX_STATS_EN
    clr_now = stat_clear;
`else
    clr_now = 1'b0;
`endif
    if (!resetn) begin
      mdl_in_pkt = 1'b0;
      mdl_next_start = 0;
      mdl_pkts = 0;
      mdl_err = 0;
    end else begin
      if (xfer) begin
        if (S_AXIS_tlast) begin
          mdl_in_pkt = 1'b0;
          mdl_next_start = cyc + 1 + int'(gap_cycles);
          mdl_pkts++;
          if (S_AXIS_tuser) mdl_err++;
        end else begin
          mdl_in_pkt = 1'b1;
        end
      end
      if (clr_now) begin
        mdl_pkts = 0;
        mdl_err = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", eth_tx_busy,
        resetn && (mdl_in_pkt || (cyc < mdl_next_start) || S_AXIS_tvalid));
`ifdef ETH_TX_STATS_EN
    chk("stat_pkts", stat_pkts, mdl_pkts);
    chk("stat_err_pkts", stat_err_pkts, mdl_err);
`endif
    if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
  endtask

  // Driver: present the head of the source queue and the chosen knobs.
  task automatic run_cycle();
    beat_t b;
    if (src_q.size() > 0) begin
      b = src_q[0];
      S_AXIS_tvalid = 1'b1;
    end else begin
      b = '0;
      S_AXIS_tvalid = 1'b0;
    end
    {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tuser} = {b.data, b.keep, b.last, b.user};
    M_AXIS_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (en_rand) tx_enable = ($urandom_range(0, 9) != 0);
    if (gap_rand) gap_cycles = 8'($urandom_range(0, 3));
`ifdef ETH_TX_STATS_EN
    stat_clear = clr_on_last && (src_q.size() > 0) && b.last;
`endif
    step();
  endtask

  task automatic run_until_empty(input string name, input int budget);
    for (int i = 0; i < budget && src_q.size() > 0; i++) run_cycle();
    chk({name, "_timeout"}, src_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[17];
    beat_t b;
    int base;

    resetn = 1'b0;
    tx_enable = 1'b0;
    gap_cycles = '0;
    S_AXIS_tvalid = 1'b0;
    {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tuser} = '0;
    M_AXIS_tready = 1'b0;
`ifdef ETH_TX_STATS_EN
    stat_clear = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Reset with source valid and MAC ready: gate must stay shut.
    tx_enable = 1'b1;
    src_q.push_back(rand_beat(1'b0, 1'b0));
    repeat (3) run_cycle();
    src_q.delete();
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_busy", eth_tx_busy, 1'b0);
`ifdef ETH_TX_STATS_EN
    chk("rst_stat_pkts", stat_pkts, 0);
`endif
    resetn = 1'b1;

    // Table: {en, s_valid, s_last, m_ready, gap, exp M_tvalid, exp S_tready}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};  // idle, disabled
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1};  // idle, enabled, no data
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};  // MAC stalls
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1};  // first beat -> PASS
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1};  // PASS ignores enable
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1};  // tlast, gap 2
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};  // gap 1/2
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0};  // gap 2/2, gap input ignored
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1};  // single beat, no gap
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1};  // single beat again
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};  // disabled in idle
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1};  // single beat, gap 1
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};  // the one dead cycle
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1};  // start -> PASS
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1};  // PASS, source idle
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1};  // tlast -> IDLE
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};  // idle, disabled
    vec_on = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = rand_beat(vecs[i].s_last, 1'($urandom_range(0, 1)));
      tx_enable = vecs[i].en;
      gap_cycles = vecs[i].gap;
      S_AXIS_tvalid = vecs[i].s_valid;
      {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tuser} = {b.data, b.keep, b.last, b.user};
      M_AXIS_tready = vecs[i].m_ready;
      vec_mv = vecs[i].exp_mv;
      vec_sr = vecs[i].exp_sr;
      if (vecs[i].s_valid && vecs[i].m_ready && vecs[i].exp_sr) exp_q.push_back(b);
      step();
    end
    vec_on = 1'b0;
    chk("vec_sb_empty", exp_q.size(), 0);

    // T1: three back-to-back 4-beat packets, no gap, no bubbles.
    tx_enable = 1'b1;
    gap_cycles = 8'd0;
    repeat (3) run_cycle();
    hs_cyc.delete();
    repeat (3) add_pkt(4, 1'b0);
    run_until_empty("t1", 40);
    chk("t1_beats", hs_cyc.size(), 12);
    if (hs_cyc.size() == 12) chk("t1_no_bubbles", hs_cyc[11] - hs_cyc[0], 11);

    // T2: gap of 5 between two 2-beat packets.
    gap_cycles = 8'd5;
    hs_cyc.delete();
    add_pkt(2, 1'b0);
    add_pkt(2, 1'b0);
    run_until_empty("t2", 40);
    chk("t2_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) chk("t2_gap", hs_cyc[2] - hs_cyc[1], 6);
    repeat (6) run_cycle();

    // T3: enable dropped after the first beat of an 8-beat packet.
    gap_cycles = 8'd0;
    tx_enable = 1'b1;
    add_pkt(8, 1'b0);
    add_pkt(2, 1'b0);
    base = m_beats;
    run_cycle();
    tx_enable = 1'b0;
    repeat (12) run_cycle();
    chk("t3_pkt_done", m_beats - base, 8);
    chk("t3_held", src_q.size(), 2);
    tx_enable = 1'b1;
    run_until_empty("t3", 20);
    chk("t3_total", m_beats - base, 10);

    // T4: 100 random packets, random MAC backpressure, enable and gap.
    rdy_rand = 1'b1;
    en_rand = 1'b1;
    gap_rand = 1'b1;
    for (int i = 0; i < 100; i++) add_pkt($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    run_until_empty("t4", 8000);
    chk("t4_sb_empty", exp_q.size(), 0);
    rdy_rand = 1'b0;
    en_rand = 1'b0;
    gap_rand = 1'b0;
    tx_enable = 1'b1;
    gap_cycles = 8'd0;
    repeat (5) run_cycle();

    // T5: one-cycle reset in the middle of a packet.
    add_pkt(6, 1'b0);
    repeat (2) run_cycle();
    chk("t5_in_pass", dbg_state, 2'd1);
    resetn = 1'b0;
    run_cycle();
    resetn = 1'b1;
    chk("t5_busy", eth_tx_busy, 1'b0);
    chk("t5_state", dbg_state, 2'd0);
    src_q.delete();
    exp_q.delete();
    base = m_beats;
    add_pkt(3, 1'b0);
    run_until_empty("t5", 20);
    chk("t5_next_pkt", m_beats - base, 3);

`ifdef ETH_TX_STATS_EN
    // T6: counters, then clear coincident with a tlast.
    stat_clear = 1'b1;
    run_cycle();
    for (int i = 0; i < 10; i++) add_pkt($urandom_range(1, 3), (i % 3) == 1);
    run_until_empty("t6", 100);
    chk("t6_pkts", stat_pkts, 10);
    chk("t6_err", stat_err_pkts, 3);
    clr_on_last = 1'b1;
    add_pkt(2, 1'b1);
    run_until_empty("t6_clr", 20);
    clr_on_last = 1'b0;
    run_cycle();
    chk("t6_pkts_clr", stat_pkts, 0);
    chk("t6_err_clr", stat_err_pkts, 0);
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
